// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
// Shared definitions for the image receive path: the image_store state
// encoding, the RGB565 pixel layout, the byte-level protocol constants shared
// with the UART image receiver, and the chunk size the receiver works in.
// ---------------------------------------------------------------------------
package image_pkg;

    // Byte-pairing states of the frame writer.
    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        FULL
    } state_t;

    // RGB565 pixel as it lands in the frame buffer (big-endian byte pair).
    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

    // Protocol bytes exchanged with the sender by the receiver.
    localparam logic [7:0] PROTO_START    = 8'h01;
    localparam logic [7:0] PROTO_END      = 8'h03;
    localparam logic [7:0] PROTO_ACK      = 8'h06;
    localparam logic [7:0] PROTO_RECEIVED = 8'h16;

    // Bytes per chunk acknowledged by the receiver.
    localparam int CHUNK_SIZE = 10240;

    // The first byte on the wire is the high half of the pixel.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/image_store_pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Register stage that joins a high byte and a low byte into one RGB565 pixel
// and presents it to the frame buffer as a one-cycle write.
//
// Ports:
//   clk, reset_n    - system clock, asynchronous active-low reset
//   i_byte          - received byte
//   i_take_hi       - latch i_byte as the high half of the next pixel
//   i_take_lo       - i_byte is the low half: issue the write next cycle
//   i_addr          - frame-buffer address for the pixel being completed
//   o_wr_en         - one-cycle write strobe
//   o_wr_addr       - registered address, held until the next write
//   o_wr_data       - registered pixel, held until the next write
// ---------------------------------------------------------------------------
module pixel_packer #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        i_byte,
    input  logic              i_take_hi,
    input  logic              i_take_lo,
    input  logic [ADDR_W:0]   i_addr,
    output logic              o_wr_en,
    output logic [ADDR_W:0]   o_wr_addr,
    output logic [15:0]       o_wr_data
);
    import image_pkg::*;

    logic [7:0]      r_hi_byte;
    logic            r_wr_en;
    logic [ADDR_W:0] r_wr_addr;
    rgb565_t         r_wr_data;

    // Holds the pending high byte and registers the completed pixel.  The
    // strobe is a pulse while address/data persist so the frame buffer side
    // can observe the last write after the strobe drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi_byte <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= i_take_lo;
            if (i_take_hi) begin
                r_hi_byte <= i_byte;
            end
            if (i_take_lo) begin
                r_wr_addr <= i_addr;
                r_wr_data <= pack_rgb565(r_hi_byte, i_byte);
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

endmodule

// File: rtl/image_store.sv
// ---------------------------------------------------------------------------
// image_store
// Consumes the receiver's byte stream, packs byte pairs into RGB565 pixels and
// writes them sequentially into a frame buffer.  Frame length is checked
// against IMG_W*IMG_H; a complete frame pulses frame_ready, a short one sets
// err_short, bytes past a full frame set err_overflow.
//
// Build option: define IMAGE_STORE_DOUBLE_BUF_EN for ping-pong buffering.
// Writes then go to wbuf (wr_addr MSB) while the display reads ~wbuf, and
// both swap on every good frame.  Without it, wr_addr MSB and disp_buf are 0.
//
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   data_in, data_valid   - received byte and its one-cycle strobe
//   image_start           - one-cycle pulse, begins (or restarts) a frame
//   image_end             - one-cycle pulse, terminates the frame
//   chunk_complete        - one-cycle pulse per chunk received
//   wr_en/wr_addr/wr_data - frame-buffer write port ({buffer, pixel index})
//   frame_ready           - one-cycle pulse on an exact-length frame
//   disp_buf              - buffer the display should read
//   busy                  - frame in progress
//   err_short             - sticky, frame ended before it was full
//   err_overflow          - sticky, bytes arrived after the frame was full
//   chunk_count           - chunks seen in this frame, saturating at 255
// ---------------------------------------------------------------------------
module image_store #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    input  logic              image_start,
    input  logic              image_end,
    input  logic              chunk_complete,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_ready,
    output logic              disp_buf,
    output logic              busy,
    output logic              err_short,
    output logic              err_overflow,
    output logic [7:0]        chunk_count
);
    import image_pkg::*;

    localparam int              PIXELS   = IMG_W * IMG_H;
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W:0] PIX_LAST = CNT_W'(PIXELS - 1);

    state_t          r_state;
    logic [ADDR_W:0] r_pix_cnt;
    logic [7:0]      r_chunk_count;
    logic            r_busy;
    logic            r_err_short;
    logic            r_err_overflow;
    logic            r_frame_ready;

    logic            w_in_frame;
    logic            w_byte;
    logic            w_take_hi;
    logic            w_take_lo;
    logic            w_last_pix;
    logic            w_end;
    logic            w_good_end;
    logic            w_wbuf;
    logic            w_disp_buf;
    logic [ADDR_W:0] w_addr;

    // A start pulse has priority over everything else in the same cycle: the
    // byte is dropped and any coincident end is treated as part of the
    // abandoned frame.  A byte coincident with an end is consumed first, so
    // the last pixel and the end may share a cycle and still count as good.
    assign w_in_frame = (r_state != IDLE);
    assign w_byte     = data_valid && !image_start && w_in_frame;
    assign w_take_hi  = w_byte && (r_state == HI);
    assign w_take_lo  = w_byte && (r_state == LO);
    assign w_last_pix = (r_pix_cnt == PIX_LAST);
    assign w_end      = image_end && !image_start && w_in_frame;
    assign w_good_end = w_end && ((r_state == FULL) || (w_take_lo && w_last_pix));
    assign w_addr     = {w_wbuf, r_pix_cnt[ADDR_W-1:0]};

`ifdef IMAGE_STORE_DOUBLE_BUF_EN
    logic r_wbuf;
    logic r_disp_buf;

    // Ping-pong select.  wbuf resets to 1 so the display initially points at
    // buffer 0; both flip together on a good frame so the display never
    // reads the buffer being filled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wbuf     <= 1'b1;
            r_disp_buf <= 1'b0;
        end else if (w_good_end) begin
            r_wbuf     <= ~r_wbuf;
            r_disp_buf <= r_wbuf;
        end
    end

    assign w_wbuf     = r_wbuf;
    assign w_disp_buf = r_disp_buf;
`else
    assign w_wbuf     = 1'b0;
    assign w_disp_buf = 1'b0;
`endif

    // Frame FSM with its counters and status flags.  Every status output is
    // registered here so all of them change on the cycle after the event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_pix_cnt      <= '0;
            r_chunk_count  <= '0;
            r_busy         <= 1'b0;
            r_err_short    <= 1'b0;
            r_err_overflow <= 1'b0;
            r_frame_ready  <= 1'b0;
        end else begin
            r_frame_ready <= w_good_end;
            if (image_start) begin
                r_state        <= HI;
                r_pix_cnt      <= '0;
                r_chunk_count  <= '0;
                r_busy         <= 1'b1;
                r_err_short    <= 1'b0;
                r_err_overflow <= 1'b0;
            end else if (w_in_frame) begin
                if (chunk_complete && (r_chunk_count != 8'hFF)) begin
                    r_chunk_count <= r_chunk_count + 8'd1;
                end
                if (w_take_lo) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
                if (data_valid && (r_state == FULL)) begin
                    r_err_overflow <= 1'b1;
                end
                if (image_end) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!w_good_end) begin
                        r_err_short <= 1'b1;
                    end
                end else begin
                    case (r_state)
                        HI: begin
                            if (data_valid) begin
                                r_state <= LO;
                            end
                        end
                        LO: begin
                            if (data_valid) begin
                                r_state <= w_last_pix ? FULL : HI;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    pixel_packer #(
        .ADDR_W    (ADDR_W)
    ) u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_byte    (data_in),
        .i_take_hi (w_take_hi),
        .i_take_lo (w_take_lo),
        .i_addr    (w_addr),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data)
    );

    assign frame_ready  = r_frame_ready;
    assign disp_buf     = w_disp_buf;
    assign busy         = r_busy;
    assign err_short    = r_err_short;
    assign err_overflow = r_err_overflow;
    assign chunk_count  = r_chunk_count;

endmodule

// File: tb/tb_image_store.sv
// ---------------------------------------------------------------------------
// tb_image_store
// Scoreboard bench for image_store on a 2x2 frame.  Stimulus tasks push the
// expected frame-buffer writes and frame_ready events into queues; a monitor
// on the falling edge pops and compares them whenever the DUT strobes.
// Per-frame status (errors, busy, chunk_count, disp_buf) is compared after
// every image_end.  Follows IMAGE_STORE_DOUBLE_BUF_EN like the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_image_store;

    localparam int IMG_W  = 2;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 2;
    localparam int PIXELS = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        data_in = '0;
    logic              data_valid = 1'b0;
    logic              image_start = 1'b0;
    logic              image_end = 1'b0;
    logic              chunk_complete = 1'b0;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [15:0]       wr_data;
    logic              frame_ready;
    logic              disp_buf;
    logic              busy;
    logic              err_short;
    logic              err_overflow;
    logic [7:0]        chunk_count;

    typedef struct {
        logic [ADDR_W:0] addr;
        logic [15:0]     data;
    } wr_t;

    wr_t    writeQ[$];
    logic   readyQ[$];
    int     checks = 0;
    int     errors = 0;
    logic   modelWbuf;
    wr_t    monWr;
    logic   monDisp;

    always #5 clk = ~clk;

    image_store #(
        .IMG_W          (IMG_W),
        .IMG_H          (IMG_H),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .image_start    (image_start),
        .image_end      (image_end),
        .chunk_complete (chunk_complete),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .frame_ready    (frame_ready),
        .disp_buf       (disp_buf),
        .busy           (busy),
        .err_short      (err_short),
        .err_overflow   (err_overflow),
        .chunk_count    (chunk_count)
    );

    // Buffer being written right after reset.
    function automatic logic initWbuf();
`ifdef IMAGE_STORE_DOUBLE_BUF_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Buffer the display should show while modelWbuf is being written.
    function automatic logic dispOf(input logic wb);
`ifdef IMAGE_STORE_DOUBLE_BUF_EN
        return ~wb;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decide whether this cycle carries a chunk pulse: random when
    // chunkPulses < 0, otherwise the first chunkPulses calls pulse.
    task automatic driveChunk(input int chunkPulses, inout int chunkCnt);
        if (chunkPulses < 0) begin
            chunk_complete = ($urandom_range(0, 3) == 0);
        end else begin
            chunk_complete = (chunkCnt < chunkPulses);
        end
        if (chunk_complete) begin
            chunkCnt++;
        end
    endtask

    // One frame: start, optional abandoned partial frame of preRestart bytes
    // restarted by a start pulse carrying a (dropped) byte, the frame bytes,
    // then image_end either alone or together with the last byte.
    task automatic applyStimulus(input logic [7:0] bytes[$], input int preRestart,
                                 input bit endWithLast, input bit gaps, input int chunkPulses);
        int         n;
        int         chunkCnt;
        bit         good;
        logic [7:0] prevByte;
        logic [7:0] b;
        wr_t        w;
        n        = bytes.size();
        chunkCnt = 0;
        prevByte = '0;

        image_start = 1'b1;
        data_valid  = 1'($urandom_range(0, 1));
        data_in     = 8'hEE;
        tick();
        image_start = 1'b0;
        data_valid  = 1'b0;
        checkOutput("busy_after_start", busy, 1);

        if (preRestart > 0) begin
            for (int i = 0; i < preRestart; i++) begin
                b          = 8'($urandom);
                data_valid = 1'b1;
                data_in    = b;
                if ((i % 2 == 1) && (i / 2 < PIXELS)) begin
                    w.addr = {modelWbuf, ADDR_W'(i / 2)};
                    w.data = {prevByte, b};
                    writeQ.push_back(w);
                end
                prevByte = b;
                tick();
            end
            image_start = 1'b1;
            data_valid  = 1'b1;
            data_in     = 8'($urandom);
            tick();
            image_start = 1'b0;
            data_valid  = 1'b0;
        end

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    driveChunk(chunkPulses, chunkCnt);
                    tick();
                    chunk_complete = 1'b0;
                end
            end
            data_valid = 1'b1;
            data_in    = bytes[i];
            driveChunk(chunkPulses, chunkCnt);
            if ((i % 2 == 1) && (i / 2 < PIXELS)) begin
                w.addr = {modelWbuf, ADDR_W'(i / 2)};
                w.data = {bytes[i-1], bytes[i]};
                writeQ.push_back(w);
            end
            if (endWithLast && (i == n - 1)) begin
                image_end = 1'b1;
            end
            tick();
            data_valid     = 1'b0;
            chunk_complete = 1'b0;
        end
        if (!(endWithLast && n > 0)) begin
            image_end = 1'b1;
            tick();
        end
        image_end = 1'b0;

        good = (n >= 2 * PIXELS);
        if (good) begin
`ifdef IMAGE_STORE_DOUBLE_BUF_EN
            modelWbuf = ~modelWbuf;
`endif
            readyQ.push_back(dispOf(modelWbuf));
        end

        @(negedge clk);
        checkOutput("frame_ready_after_end", frame_ready, good);
        checkOutput("err_short", err_short, !good);
        checkOutput("err_overflow", err_overflow, (n > 2 * PIXELS));
        checkOutput("busy_after_end", busy, 0);
        checkOutput("chunk_count", chunk_count, (chunkCnt > 255) ? 255 : chunkCnt);
        checkOutput("disp_buf_after_end", disp_buf, dispOf(modelWbuf));
        @(negedge clk);
        checkOutput("frame_ready_one_cycle", frame_ready, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr_en"}, wr_en, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_frame_ready"}, frame_ready, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_disp_buf"}, disp_buf, 0);
        checkOutput({tag, "_err_short"}, err_short, 0);
        checkOutput({tag, "_err_overflow"}, err_overflow, 0);
        checkOutput({tag, "_chunk_count"}, chunk_count, 0);
    endtask

    // Monitor: every write and every frame_ready must match the next
    // expectation queued by the stimulus side.
    always @(negedge clk) begin
        if (wr_en) begin
            if (writeQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: addr %0h data %0h while none expected", wr_addr, wr_data);
            end else begin
                monWr = writeQ.pop_front();
                checkOutput("wr_addr", wr_addr, monWr.addr);
                checkOutput("wr_data", wr_data, monWr.data);
            end
        end
        if (frame_ready) begin
            if (readyQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame_ready: disp_buf %0h while no frame expected", disp_buf);
            end else begin
                monDisp = readyQ.pop_front();
                checkOutput("disp_buf_at_frame_ready", disp_buf, monDisp);
            end
        end
    end

    initial begin
        logic [7:0] fb[$];
        int         n;

        modelWbuf = initWbuf();
        #12;
        checkResetValues("reset");
        #1 reset_n = 1'b1;
        tick();

        // Bytes while idle are ignored.
        data_valid = 1'b1;
        data_in    = 8'hA5;
        tick();
        data_in    = 8'h5A;
        tick();
        data_valid = 1'b0;
        tick();
        checkOutput("idle_busy", busy, 0);

        $display("[TB] exact 2x2 frame");
        fb.delete();
        fb.push_back(8'h12); fb.push_back(8'h34); fb.push_back(8'h56); fb.push_back(8'h78);
        fb.push_back(8'h9A); fb.push_back(8'hBC); fb.push_back(8'hDE); fb.push_back(8'hF0);
        applyStimulus(fb, 0, 1'b0, 1'b0, 0);

        $display("[TB] short frame");
        fb.delete();
        for (int i = 0; i < 5; i++) fb.push_back(8'($urandom));
        applyStimulus(fb, 0, 1'b0, 1'b0, 0);

        $display("[TB] overflow frame");
        fb.delete();
        for (int i = 0; i < 10; i++) fb.push_back(8'($urandom));
        applyStimulus(fb, 0, 1'b0, 1'b0, 0);

        $display("[TB] restart after 3 bytes, end with last byte");
        fb.delete();
        for (int i = 0; i < 8; i++) fb.push_back(8'($urandom));
        applyStimulus(fb, 3, 1'b1, 1'b0, 0);

        $display("[TB] async reset in LO");
        image_start = 1'b1;
        tick();
        image_start = 1'b0;
        data_valid  = 1'b1;
        data_in     = 8'h11;
        tick();
        data_in     = 8'h22;
        writeQ.push_back('{addr: {modelWbuf, ADDR_W'(0)}, data: 16'h1122});
        tick();
        data_in     = 8'h33;
        tick();
        data_valid  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkResetValues("midreset");
        data_valid = 1'b1;
        data_in    = 8'h44;
        tick();
        tick();
        data_valid = 1'b0;
        checkOutput("reset_held_wr_en", wr_en, 0);
        reset_n   = 1'b1;
        modelWbuf = initWbuf();
        tick();

        $display("[TB] three chunk pulses");
        fb.delete();
        for (int i = 0; i < 8; i++) fb.push_back(8'($urandom));
        applyStimulus(fb, 0, 1'b0, 1'b0, 3);

        $display("[TB] chunk_count saturation");
        image_start = 1'b1;
        tick();
        image_start    = 1'b0;
        chunk_complete = 1'b1;
        repeat (260) tick();
        chunk_complete = 1'b0;
        image_end      = 1'b1;
        tick();
        image_end = 1'b0;
        @(negedge clk);
        checkOutput("chunk_count_saturated", chunk_count, 255);
        checkOutput("sat_err_short", err_short, 1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 40; f++) begin
            fb.delete();
            n = $urandom_range(0, 11);
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            applyStimulus(fb, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
                          1'($urandom_range(0, 1)), 1'b1, -1);
        end

        repeat (3) tick();
        checkOutput("write_queue_drained", writeQ.size(), 0);
        checkOutput("ready_queue_drained", readyQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
